// File: rtl/acc_pktgen.sv
// MoSAIC traffic initiator/checker: sends numbered packets to a loopback tile and checks what comes back.
// Define ACC_PKTGEN_CHECK_EN to build the RX checker; otherwise RX is a counting sink.
module acc_pktgen #(
    parameter int BW      = 32,
    parameter int BWB     = BW / 8,
    parameter int XY_SZ   = 3,
    parameter int LEN_W   = 8,
    parameter int CNT_W   = 16,
    parameter int MAX_OUT = 4,
    localparam int OW     = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_low,
    input  logic [2*XY_SZ-1:0]   HsrcId,
    input  logic                 cfg_start,
    input  logic [2*XY_SZ-1:0]   cfg_dest,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [CNT_W-1:0]     cfg_num_pkts,
    output logic                 stream_out_TVALID,
    output logic [BW-1:0]        stream_out_TDATA,
    output logic [BWB-1:0]       stream_out_TKEEP,
    output logic                 stream_out_TLAST,
    input  logic                 stream_out_TREADY,
    input  logic                 stream_in_TVALID,
    input  logic [BW-1:0]        stream_in_TDATA,
    input  logic [BWB-1:0]       stream_in_TKEEP,
    input  logic                 stream_in_TLAST,
    output logic                 stream_in_TREADY,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     tx_count,
    output logic [CNT_W-1:0]     rx_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [OW-1:0]        outstanding
);

    localparam int SW = BW - 4 * XY_SZ;
    localparam logic [BW-1:0] LO_MASK = {{(BW - BW/2){1'b0}}, {(BW/2){1'b1}}};

    function automatic logic [BW-1:0] hdr_word(
        input logic [CNT_W-1:0]   seq,
        input logic [2*XY_SZ-1:0] src,
        input logic [2*XY_SZ-1:0] dst
    );
        return {SW'(seq), src, dst};
    endfunction

    function automatic logic [BW-1:0] pay_word(
        input logic [CNT_W-1:0] seq,
        input logic [LEN_W:0]   k
    );
        return (BW'(seq) << (BW/2)) | (BW'(k) & LO_MASK);
    endfunction

    typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_PAY} tx_state_t;

    tx_state_t            tx_st;
    logic [LEN_W-1:0]     tx_k;
    logic [2*XY_SZ-1:0]   dest_q;
    logic [LEN_W-1:0]     len_q;
    logic [CNT_W-1:0]     num_q;

    logic                 accept;
    logic                 tx_hs;
    logic                 hdr_hs;
    logic                 tx_pkt;
    logic                 rx_hs;
    logic                 rx_inc;
    logic                 err_inc;
    logic                 out_dec;
    logic                 can_send;
    logic [CNT_W-1:0]     tx_nxt;
    logic [CNT_W-1:0]     rx_nxt;
    logic [OW-1:0]        out_nxt;
    logic [BW-1:0]        next_hdr;

    assign accept   = cfg_start && !busy;
    assign tx_hs    = stream_out_TVALID && stream_out_TREADY;
    assign hdr_hs   = tx_hs && (tx_st == TX_HDR);
    assign tx_pkt   = tx_hs && stream_out_TLAST;
    assign rx_hs    = stream_in_TVALID && stream_in_TREADY;
    assign tx_nxt   = tx_count + CNT_W'(tx_pkt);
    assign rx_nxt   = rx_count + CNT_W'(rx_inc);
    // A same-cycle header send lets a return retire even from zero.
    assign out_dec  = rx_inc && ((outstanding != '0) || hdr_hs);
    assign out_nxt  = outstanding + OW'(hdr_hs) - OW'(out_dec);
    assign can_send = busy && (tx_nxt < num_q) && (out_nxt < OW'(MAX_OUT));
    assign next_hdr = hdr_word(tx_nxt, HsrcId, dest_q);

    assign stream_out_TKEEP = {BWB{stream_out_TVALID}};

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            dest_q      <= '0;
            len_q       <= '0;
            num_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tx_count    <= '0;
            rx_count    <= '0;
            err_count   <= '0;
            outstanding <= '0;
        end else if (accept) begin
            dest_q      <= cfg_dest;
            len_q       <= cfg_len;
            num_q       <= cfg_num_pkts;
            busy        <= (cfg_num_pkts != '0);
            done        <= (cfg_num_pkts == '0);
            tx_count    <= '0;
            rx_count    <= '0;
            err_count   <= '0;
            outstanding <= '0;
        end else begin
            tx_count    <= tx_nxt;
            rx_count    <= rx_nxt;
            outstanding <= out_nxt;
            if (err_inc && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (busy && (tx_nxt == num_q) && (rx_nxt == num_q)) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            tx_st             <= TX_IDLE;
            tx_k              <= '0;
            stream_out_TVALID <= 1'b0;
            stream_out_TDATA  <= '0;
            stream_out_TLAST  <= 1'b0;
        end else begin
            unique case (tx_st)
                TX_IDLE: begin
                    if (can_send) begin
                        stream_out_TVALID <= 1'b1;
                        stream_out_TDATA  <= next_hdr;
                        stream_out_TLAST  <= (len_q == '0);
                        tx_st             <= TX_HDR;
                    end
                end
                TX_HDR, TX_PAY: begin
                    if (tx_hs && stream_out_TLAST) begin
                        // Packet finished: chain the next header or park.
                        if (can_send) begin
                            stream_out_TDATA <= next_hdr;
                            stream_out_TLAST <= (len_q == '0);
                            tx_st            <= TX_HDR;
                        end else begin
                            stream_out_TVALID <= 1'b0;
                            stream_out_TLAST  <= 1'b0;
                            tx_st             <= TX_IDLE;
                        end
                    end else if (tx_hs && (tx_st == TX_HDR)) begin
                        stream_out_TDATA <= pay_word(tx_count, '0);
                        stream_out_TLAST <= (len_q == LEN_W'(1));
                        tx_k             <= LEN_W'(1);
                        tx_st            <= TX_PAY;
                    end else if (tx_hs) begin
                        stream_out_TDATA <= pay_word(tx_count, {1'b0, tx_k});
                        stream_out_TLAST <= (tx_k == len_q - LEN_W'(1));
                        tx_k             <= tx_k + LEN_W'(1);
                    end
                end
                default: tx_st <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            stream_in_TREADY <= 1'b0;
        end else begin
            stream_in_TREADY <= 1'b1;
        end
    end

`ifdef ACC_PKTGEN_CHECK_EN
    typedef enum logic {RX_HDR, RX_PAY} rx_state_t;

    rx_state_t        rx_st;
    logic [LEN_W:0]   rx_idx;
    logic             rx_bad;
    logic             rx_stray;
    logic [BW-1:0]    exp_hdr;
    logic [BW-1:0]    exp_pay;
    logic             word_bad;
    logic             last_bad;
    logic             stray_now;
    logic             bad_fin;
    logic             rx_fin;
    logic             unused_keep;

    assign unused_keep = ^stream_in_TKEEP;
    assign exp_hdr     = hdr_word(rx_count, dest_q, HsrcId);
    assign exp_pay     = pay_word(rx_count, rx_idx);
    assign rx_fin      = rx_hs && stream_in_TLAST;

    always_comb begin
        word_bad  = 1'b0;
        last_bad  = 1'b0;
        stray_now = rx_stray;
        if (rx_st == RX_HDR) begin
            word_bad  = (stream_in_TDATA != exp_hdr);
            last_bad  = (len_q != '0);
            stray_now = (outstanding == '0);
        end else begin
            word_bad = (rx_idx >= {1'b0, len_q}) || (stream_in_TDATA != exp_pay);
            last_bad = ((rx_idx + (LEN_W+1)'(1)) != {1'b0, len_q});
        end
        bad_fin = word_bad || last_bad || ((rx_st == RX_PAY) && rx_bad);
    end

    assign rx_inc  = rx_fin && !stray_now;
    assign err_inc = rx_fin && (stray_now || bad_fin);

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            rx_st    <= RX_HDR;
            rx_idx   <= '0;
            rx_bad   <= 1'b0;
            rx_stray <= 1'b0;
        end else if (rx_hs) begin
            unique case (rx_st)
                RX_HDR: begin
                    if (!stream_in_TLAST) begin
                        rx_st    <= RX_PAY;
                        rx_idx   <= '0;
                        rx_bad   <= word_bad;
                        rx_stray <= (outstanding == '0);
                    end
                end
                RX_PAY: begin
                    if (stream_in_TLAST) begin
                        rx_st <= RX_HDR;
                    end else begin
                        // Saturate so a runaway packet stays flagged over-length.
                        if (rx_idx != '1) begin
                            rx_idx <= rx_idx + (LEN_W+1)'(1);
                        end
                        rx_bad <= rx_bad || word_bad;
                    end
                end
                default: rx_st <= RX_HDR;
            endcase
        end
    end
`else
    logic unused_in;

    assign unused_in = ^{stream_in_TDATA, stream_in_TKEEP};
    assign rx_inc    = rx_hs && stream_in_TLAST;
    assign err_inc   = 1'b0;
`endif

endmodule

// File: tb/tb_acc_pktgen.sv
// Bench for acc_pktgen: loopback model that swaps src/dest, with stall,
// hold-off, corruption and truncation knobs; table-driven runs plus corner sequences.
module tb_acc_pktgen;
    localparam int BW  = 32;
    localparam int BWB = 4;
    localparam int XY  = 3;
    localparam int LW  = 8;
    localparam int CW  = 16;
    localparam int MO  = 4;
    localparam int OW  = 3;
`ifdef ACC_PKTGEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_low;
    logic [2*XY-1:0] src_id;
    logic           cfg_start;
    logic [2*XY-1:0] cfg_dest;
    logic [LW-1:0]  cfg_len;
    logic [CW-1:0]  cfg_num;
    logic           o_valid;
    logic [BW-1:0]  o_data;
    logic [BWB-1:0] o_keep;
    logic           o_last;
    logic           o_ready;
    logic           in_valid;
    logic [BW-1:0]  in_data;
    logic           in_last;
    logic           i_ready;
    logic           busy;
    logic           done;
    logic [CW-1:0]  tx_count;
    logic [CW-1:0]  rx_count;
    logic [CW-1:0]  err_count;
    logic [OW-1:0]  outstanding;

    always #5 clk = ~clk;

    acc_pktgen #(
        .BW(BW), .BWB(BWB), .XY_SZ(XY), .LEN_W(LW), .CNT_W(CW), .MAX_OUT(MO)
    ) dut (
        .clk_line          (clk),
        .clk_line_rst_low  (rst_low),
        .HsrcId            (src_id),
        .cfg_start         (cfg_start),
        .cfg_dest          (cfg_dest),
        .cfg_len           (cfg_len),
        .cfg_num_pkts      (cfg_num),
        .stream_out_TVALID (o_valid),
        .stream_out_TDATA  (o_data),
        .stream_out_TKEEP  (o_keep),
        .stream_out_TLAST  (o_last),
        .stream_out_TREADY (o_ready),
        .stream_in_TVALID  (in_valid),
        .stream_in_TDATA   (in_data),
        .stream_in_TKEEP   ({BWB{1'b1}}),
        .stream_in_TLAST   (in_last),
        .stream_in_TREADY  (i_ready),
        .busy              (busy),
        .done              (done),
        .tx_count          (tx_count),
        .rx_count          (rx_count),
        .err_count         (err_count),
        .outstanding       (outstanding)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } w_t;

    w_t  lb_q[$];
    w_t  pkt_buf[$];
    bit  stall_en  = 1'b0;
    bit  lb_hold   = 1'b0;
    int  cor_pkt   = -1;
    int  cor_word  = 2;
    int  short_pkt = -1;
    int  inj_req   = 0;
    int  mon_pkt   = 0;
    int  mon_k     = -1;
    int  mon_len   = 0;
    logic [2*XY-1:0] mon_dest = '0;

    // Loopback: checks TX words, buffers whole packets, returns them swapped.
    initial begin : loopback
        w_t          w;
        logic [31:0] exp_w;
        logic [31:0] rw;
        logic        exp_l;
        bit          in_taken = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        int          inj_seen = 0;
        o_ready  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_low) begin
                lb_q.delete();
                pkt_buf.delete();
                in_valid   = 1'b0;
                in_taken   = 1'b0;
                prev_stall = 1'b0;
                mon_pkt    = 0;
                mon_k      = -1;
            end else begin
                if (cfg_start && !busy) begin
                    mon_len  = int'(cfg_len);
                    mon_dest = cfg_dest;
                    mon_pkt  = 0;
                    mon_k    = -1;
                end
                if (prev_stall) begin
                    chk("stall_data", o_data, prev_data);
                    chk("stall_ctl", {30'd0, o_valid, o_last}, {30'd0, 1'b1, prev_last});
                end
                prev_stall = o_valid && !o_ready;
                prev_data  = o_data;
                prev_last  = o_last;
                if (o_valid && o_ready) begin
                    if (mon_k < 0) begin
                        exp_w = {20'(mon_pkt), src_id, mon_dest};
                        exp_l = (mon_len == 0);
                        rw    = {o_data[31:12], o_data[5:0], o_data[11:6]};
                    end else begin
                        exp_w = {16'(mon_pkt), 16'(mon_k)};
                        exp_l = (mon_k == mon_len - 1);
                        rw    = o_data;
                        if (mon_pkt == cor_pkt && mon_k == cor_word) rw = rw ^ 32'h100;
                    end
                    chk("tx_word", o_data, exp_w);
                    chk("tx_last", {31'd0, o_last}, {31'd0, exp_l});
                    chk("tx_keep", {28'd0, o_keep}, 32'hf);
                    if (mon_pkt == short_pkt && o_last && mon_k >= 1) begin
                        pkt_buf[pkt_buf.size()-1].l = 1'b1;
                    end else begin
                        pkt_buf.push_back({rw, o_last});
                    end
                    if (o_last) begin
                        foreach (pkt_buf[j]) lb_q.push_back(pkt_buf[j]);
                        pkt_buf.delete();
                        mon_pkt++;
                        mon_k = -1;
                    end else begin
                        mon_k++;
                    end
                end
                in_taken = in_valid && i_ready;
            end
            @(posedge clk);
            #1;
            o_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_taken) begin
                in_valid = 1'b0;
                in_taken = 1'b0;
            end
            if (inj_req != inj_seen) begin
                inj_seen = inj_req;
                lb_q.push_back({32'h0, 1'b1});
            end
            if (!in_valid && !lb_hold && lb_q.size() > 0) begin
                w        = lb_q.pop_front();
                in_valid = 1'b1;
                in_data  = w.d;
                in_last  = w.l;
            end
        end
    end

    task automatic start(input int len, input int num, input logic [5:0] dest);
        @(posedge clk);
        #1;
        cfg_len   = LW'(len);
        cfg_num   = CW'(num);
        cfg_dest  = dest;
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 4000);
        chk(name, {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        int         len;
        int         num;
        logic [5:0] dest;
        bit         stall;
        int         cpkt;
        int         spkt;
        int         e_tx;
        int         e_rx;
        int         e_err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        vecs[0] = '{3, 1, {3'd1, 3'd2}, 1'b0, -1, -1, 1, 1, 0};
        vecs[1] = '{8, 20, {3'd4, 3'd1}, 1'b1, -1, -1, 20, 20, 0};
        vecs[2] = '{4, 10, {3'd2, 3'd7}, 1'b0, 3, 7, 10, 10, CHK ? 2 : 0};
        vecs[3] = '{0, 3, {3'd0, 3'd3}, 1'b0, -1, -1, 3, 3, 0};
        vecs[4] = '{1, 6, {3'd7, 3'd7}, 1'b1, -1, -1, 6, 6, 0};
        vecs[5] = '{5, 0, {3'd3, 3'd3}, 1'b0, -1, -1, 0, 0, 0};

        rst_low   = 1'b0;
        src_id    = {3'd5, 3'd6};
        cfg_start = 1'b0;
        cfg_dest  = '0;
        cfg_len   = '0;
        cfg_num   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {27'd0, o_valid, o_last, i_ready, busy, done}, 32'd0);
        chk("rst_keep_out", {25'd0, o_keep, outstanding}, 32'd0);
        @(posedge clk);
        #1;
        rst_low = 1'b1;
        @(negedge clk);
        chk("rdy_before_edge", {31'd0, i_ready}, 32'd0);
        @(negedge clk);
        chk("rdy_after_edge", {31'd0, i_ready}, 32'd1);

        // Latency and in-flight limit with the loopback held off.
        lb_hold = 1'b1;
        @(posedge clk);
        #1;
        cfg_len   = '0;
        cfg_num   = CW'(5);
        cfg_dest  = {3'd2, 3'd3};
        cfg_start = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        @(negedge clk);
        chk("lat_n_valid", {30'd0, o_valid, busy}, 32'd1);
        @(negedge clk);
        chk("lat_n1_valid", {30'd0, o_valid, o_last}, 32'd3);
        chk("lat_hdr", o_data, {20'd0, src_id, 3'd2, 3'd3});
        repeat (40) @(negedge clk);
        chk("hold_tx", {16'd0, tx_count}, 32'd4);
        chk("hold_out", {29'd0, outstanding}, 32'd4);
        chk("hold_idle", {15'd0, o_valid, rx_count}, 32'd0);
        lb_hold = 1'b0;
        wait_done("hold_done");
        chk("hold_cnt", {tx_count, rx_count}, {16'd5, 16'd5});
        chk("hold_end", {15'd0, busy, err_count}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            cor_pkt   = vecs[i].cpkt;
            short_pkt = vecs[i].spkt;
            stall_en  = vecs[i].stall;
            start(vecs[i].len, vecs[i].num, vecs[i].dest);
            wait_done("vec_done");
            chk("vec_tx", {16'd0, tx_count}, 32'(vecs[i].e_tx));
            chk("vec_rx", {16'd0, rx_count}, 32'(vecs[i].e_rx));
            chk("vec_err", {16'd0, err_count}, 32'(vecs[i].e_err));
            chk("vec_idle", {28'd0, busy, outstanding}, 32'd0);
        end
        stall_en  = 1'b0;
        cor_pkt   = -1;
        short_pkt = -1;

        // Stray packet while idle.
        start(2, 0, {3'd1, 3'd1});
        inj_req++;
        repeat (10) @(negedge clk);
        chk("stray_err", {16'd0, err_count}, CHK ? 32'd1 : 32'd0);
        chk("stray_rx", {16'd0, rx_count}, CHK ? 32'd0 : 32'd1);
        chk("stray_out", {29'd0, outstanding}, 32'd0);

        // cfg_start while busy is ignored.
        lb_hold = 1'b1;
        start(2, 3, {3'd1, 3'd1});
        repeat (30) @(negedge clk);
        chk("busy_tx", {15'd0, busy, tx_count}, {15'd0, 1'b1, 16'd3});
        chk("busy_err", {16'd0, err_count}, 32'd0);
        start(5, 9, {3'd2, 3'd2});
        repeat (5) @(negedge clk);
        chk("ign_tx", {15'd0, busy, tx_count}, {15'd0, 1'b1, 16'd3});
        chk("ign_out", {28'd0, done, outstanding}, 32'd3);
        lb_hold = 1'b0;
        wait_done("ign_done");
        chk("ign_cnt", {tx_count, rx_count}, {16'd3, 16'd3});
        chk("ign_err", {16'd0, err_count}, 32'd0);

        // Asynchronous reset in the middle of a payload.
        start(4, 5, {3'd1, 3'd2});
        n = 0;
        while (!(mon_pkt == 2 && mon_k >= 1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_reach", {31'd0, n < 2000}, 32'd1);
        #2;
        rst_low = 1'b0;
        #1;
        chk("mid_ctl", {23'd0, o_valid, o_last, i_ready, busy, done, o_keep}, 32'd0);
        chk("mid_data", o_data, 32'd0);
        chk("mid_cnt", {tx_count, rx_count}, 32'd0);
        chk("mid_err", {13'd0, outstanding, err_count}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_low = 1'b1;
        start(2, 3, {3'd3, 3'd4});
        wait_done("fresh_done");
        chk("fresh_cnt", {tx_count, rx_count}, {16'd3, 16'd3});
        chk("fresh_err", {16'd0, err_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_pktgen.md
# acc_pktgen

Traffic initiator and checker accelerator for a MoSAIC tile. It sits on the tile switch's local port and generates a programmed number of fixed-length packets addressed to a remote tile. A loopback tile at that address returns every packet to its source. The block then checks each returned packet's header, sequence number, payload and length. It exposes counters for bring-up and NoC stress tests.

## Interface
- BW, 32, stream data width
- BWB, BW/8, TKEEP width
- XY_SZ, 3, width of one tile coordinate
- LEN_W, 8, width of payload-length field
- CNT_W, 16, width of packet counters; must satisfy CNT_W ≤ BW-4*XY_SZ
- MAX_OUT, 4, maximum packets in flight (≥1)

- clk_line  in  1  line clock
- clk_line_rst_low  in  1  asynchronous active-low reset
- HsrcId  in  2*XY_SZ  own {Y,X}
- cfg_start  in  1  single-cycle start pulse
- cfg_dest  in  2*XY_SZ  destination {Y,X}
- cfg_len  in  LEN_W  payload words per packet (0 = header only)
- cfg_num_pkts  in  CNT_W  packets to send
- stream_out_TVALID/TDATA/TKEEP/TLAST  out  1/BW/BWB/1  to switch local input
- stream_out_TREADY  in  1
- stream_in_TVALID/TDATA/TKEEP/TLAST  in  1/BW/BWB/1  from switch local output
- stream_in_TREADY  out  1
- busy  out  1  run in progress
- done  out  1  sticky completion flag
- tx_count, rx_count  out  CNT_W  packets sent / good-or-bad packets received
- err_count  out  CNT_W  saturating bad-packet count
- outstanding  out  $clog2(MAX_OUT+1)  packets in flight

## Operation
- Header word layout:
  - [XY_SZ-1:0] dest X
  - [2XY_SZ-1:XY_SZ] dest Y
  - [3XY_SZ-1:2XY_SZ] src X
  - [4XY_SZ-1:3XY_SZ] src Y
  - [BW-1:4XY_SZ] sequence number, zero-extended
- Payload word k (k = 0..cfg_len-1) = {seq[BW/2-1:0], k[BW/2-1:0]}. Both fields wrap mod 2^(BW/2).
- TKEEP is all ones. TLAST is set on the last word; for cfg_len=0 it is set on the header.
- cfg_start is accepted only when busy=0.
  - On accept: latch cfg_*, clear all counters, clear done, set busy.
  - cfg_start while busy: ignored.
  - cfg_num_pkts=0: done is set the cycle after accept; busy stays 0.
- TX FSM: IDLE → HDR → PAY → (HDR | IDLE).
  - HDR is entered only when outstanding < MAX_OUT and tx_count < num_pkts.
  - The header handshake increments outstanding.
  - The TLAST handshake increments tx_count and the sequence number.
  - From PAY: next state is HDR if packets remain and the in-flight limit allows; otherwise IDLE, waiting until the limit allows.
- RX FSM: WAIT_HDR → PAY → WAIT_HDR.
  - Expected returned header has dest = HsrcId, src = latched cfg_dest, seq = rx_count.
  - A packet is bad on any of the following:
    - any header field mismatch
    - any payload word mismatch
    - TLAST earlier or later than cfg_len words after the header
    - a packet arriving when outstanding=0
  - On the TLAST handshake: rx_count++ and outstanding--, except for a packet that arrived when outstanding=0, which only increments err_count.
  - A bad packet increments err_count exactly once. err_count saturates at all ones.
  - An over-length packet is consumed to its TLAST.
- Same-cycle TX header handshake and RX TLAST handshake: outstanding is unchanged.
- done is set when tx_count = rx_count = num_pkts; busy clears in the same cycle.

## Timing
- Reset values: all outputs 0 (including stream_in_TREADY), FSMs in IDLE / WAIT_HDR.
- stream_in_TREADY goes to 1 the first clk_line edge after reset release and stays 1. The block never backpressures.
- Latency: accepting cfg_start at edge N gives stream_out_TVALID=1 with the header after edge N+1.
- No bubbles between words, or between packets when the in-flight limit allows.
- AXIS rules: once TVALID is high, TDATA/TLAST/TKEEP stay stable and TVALID stays high until TREADY. A stalled word is never dropped or reordered.
- Counters update on the edge that completes the qualifying handshake. done and err_count are visible the cycle after the final TLAST handshake.
- Reset asserted mid-run: all state clears immediately (asynchronous), and any partial packet is abandoned.

## Configuration
- ACC_PKTGEN_CHECK_EN defined: full RX checker as described.
- Not defined: RX is a sink. stream_in_TREADY still goes to 1 after reset. Each TLAST decrements outstanding (floored at 0) and increments rx_count. err_count is tied to 0; no comparison logic is built.

## Test plan
- Reset release, then cfg_dest={1,2}, cfg_len=3, num_pkts=1 with a loopback model returning src/dest-swapped packets → header then words 0x00000000..0x00000002; done=1, rx_count=1, err_count=0.
- cfg_len=0, num_pkts=5, MAX_OUT=4, loopback held off → exactly 4 header-only TLAST packets, outstanding=4, TX stalls. Release the loopback → 5th packet sent, done=1.
- Random stream_out_TREADY stalls (50%), cfg_len=8, num_pkts=20 → TDATA stable during stalls, tx_count=rx_count=20, err_count=0.
- Loopback corrupts payload word 2 of packet 3 and returns packet 7 one word short → err_count=2, rx_count=num_pkts, done=1.
- Inject a packet while idle (outstanding=0) → err_count=1, rx_count=0; cfg_start pulsed again while busy → ignored, counters unchanged.
- Assert clk_line_rst_low during packet 2's payload → all outputs 0 immediately; a fresh start after release runs cleanly from seq 0.
